// File: rtl/lut_mem_preloader_pkg.sv
// Shared types and default widths for the LUT-to-memory preloader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lut_preload_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int IDX_W_DEF  = 6;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/lut_mem_preloader.sv
// Copies constant LUT entries 0..NUM_ENTRIES-1 into data memory at BASE_ADDR+index after a start pulse.
// Latency: 2 cycles per entry with mem_ready high; done rises 2*NUM_ENTRIES cycles after start is sampled.
// Backpressure: mem_ready low in WRITE stalls indefinitely with outputs frozen. Optional macro: LUT_PRELOAD_CHECKSUM_EN.
module lut_mem_preloader
   import lut_preload_pkg::*;
#(
   parameter int                NUM_ENTRIES = 14,
   parameter int                IDX_W       = IDX_W_DEF,
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [IDX_W-1:0]  lut_idx,
   input  logic [DATA_W-1:0] lut_val,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             capture;

   // The index register is driven straight to the LUT so lut_idx tracks idx in every state.
   assign lut_idx = idx;

   // Next-state logic: one FETCH then one WRITE per entry; start only acts from IDLE or DONE.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      capture   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = FETCH;
               idx_nxt   = '0;
            end
         end
         FETCH: begin
            state_nxt = WRITE;
            capture   = 1'b1;
         end
         WRITE: begin
            if (mem_ready) begin
               if (idx == LAST_IDX) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = FETCH;
                  idx_nxt   = idx + IDX_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // State, index and status flags; flags are decoded from the next state so they are flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         mem_we <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         mem_we <= (state_nxt == WRITE);
         busy   <= (state_nxt == FETCH) || (state_nxt == WRITE);
         done   <= (state_nxt == DONE);
      end
   end

   // Write address and data are captured once in FETCH and held through any WRITE stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (capture) begin
         mem_addr  <= BASE_ADDR + ADDR_W'(idx);
         mem_wdata <= lut_val;
      end
   end

`ifdef LUT_PRELOAD_CHECKSUM_EN
   // Running sum of accepted write data, cleared whenever a new pass is started.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         checksum <= '0;
      end else if (((state == IDLE) || (state == DONE)) && start) begin
         checksum <= '0;
      end else if ((state == WRITE) && mem_ready) begin
         checksum <= checksum + mem_wdata;
      end
   end
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_lut_mem_preloader.sv
// Self-checking bench: two preloader instances (base 0 and base 250) share inputs and see their own LUT ports.
// Latency: expected done edge derived from 2 cycles per entry plus counted stall cycles.
// Backpressure: mem_ready driven by fixed and random patterns; accepted writes captured into queues.
`timescale 1ns/1ps
module tb_lut_mem_preloader;

   localparam int N      = 14;
   localparam int BASE_B = 250;

   logic       clk;
   logic       reset;
   logic       start;
   logic       mem_ready;
   logic [7:0] lut [N];

   logic [5:0] lut_idx_a, lut_idx_b;
   logic [7:0] lut_val_a, lut_val_b;
   logic       mem_we_a, mem_we_b;
   logic [7:0] mem_addr_a, mem_addr_b;
   logic [7:0] mem_wdata_a, mem_wdata_b;
   logic       busy_a, busy_b, done_a, done_b;
   logic [7:0] checksum_a, checksum_b;

   logic [7:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];

   int n_checks = 0;
   int n_fail   = 0;

   assign lut_val_a = (lut_idx_a < 6'(N)) ? lut[lut_idx_a[3:0]] : 8'h00;
   assign lut_val_b = (lut_idx_b < 6'(N)) ? lut[lut_idx_b[3:0]] : 8'h00;

   lut_mem_preloader #(.NUM_ENTRIES(N)) dut (
      .clk(clk), .reset(reset), .start(start),
      .lut_idx(lut_idx_a), .lut_val(lut_val_a),
      .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .mem_ready(mem_ready), .busy(busy_a), .done(done_a), .checksum(checksum_a)
   );

   lut_mem_preloader #(.NUM_ENTRIES(N), .BASE_ADDR(8'(BASE_B))) dut_b (
      .clk(clk), .reset(reset), .start(start),
      .lut_idx(lut_idx_b), .lut_val(lut_val_b),
      .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_ready(mem_ready), .busy(busy_b), .done(done_b), .checksum(checksum_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record every accepted write exactly as the memory would see it.
   always @(posedge clk) begin
      if (mem_we_a && mem_ready) begin
         qa_addr.push_back(mem_addr_a);
         qa_data.push_back(mem_wdata_a);
      end
      if (mem_we_b && mem_ready) begin
         qb_addr.push_back(mem_addr_b);
         qb_data.push_back(mem_wdata_b);
      end
   end

   task automatic step(input logic st, input logic rdy);
      start     = st;
      mem_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_queues();
      qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
   endtask

   task automatic randomize_lut();
      for (int i = 0; i < N; i++) lut[i] = 8'($urandom_range(0, 255));
   endtask

   // Reference checksum: plain modular sum of the table, or zero when the feature is built out.
   function automatic logic [7:0] model_checksum();
      int s = 0;
      for (int i = 0; i < N; i++) s += lut[i];
`ifdef LUT_PRELOAD_CHECKSUM_EN
      return 8'(s % 256);
`else
      return 8'(s * 0);
`endif
   endfunction

   // Drives one pass: edge 1 samples start; returns edge count when done is seen, stalls and first write edge.
   task automatic do_pass(input bit rand_rdy, input int extra_start_idx,
                          output int edges, output int stalls, output int first_we);
      logic st, rdy;
      bit   pulsed;
      pulsed = 0; stalls = 0; first_we = -1;
      clear_queues();
      step(1'b1, 1'b1);
      edges = 1;
      while (!done_a && edges < 500) begin
         st  = 1'b0;
         rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (extra_start_idx >= 0 && !pulsed && busy_a && lut_idx_a == 6'(extra_start_idx)) begin
            st = 1'b1;
            pulsed = 1;
         end
         if (mem_we_a && first_we < 0) first_we = edges;
         if (mem_we_a && !rdy) stalls++;
         step(st, rdy);
         edges++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({mem_we_a, busy_a, done_a, lut_idx_a, mem_addr_a, mem_wdata_a, checksum_a} !== '0) begin
         n_fail++;
         $display("FAIL reset_a: outputs %h required 0",
                  {mem_we_a, busy_a, done_a, lut_idx_a, mem_addr_a, mem_wdata_a, checksum_a});
      end
      n_checks++;
      if ({mem_we_b, busy_b, done_b, lut_idx_b, mem_addr_b, mem_wdata_b, checksum_b} !== '0) begin
         n_fail++;
         $display("FAIL reset_b: outputs %h required 0",
                  {mem_we_b, busy_b, done_b, lut_idx_b, mem_addr_b, mem_wdata_b, checksum_b});
      end
      reset = 1'b0;
      step(1'b0, 1'b1);
      n_checks++;
      if (busy_a !== 1'b0 || mem_we_a !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_start: busy=%0b we=%0b required 0", busy_a, mem_we_a);
      end
   endtask

   task automatic test_basic();
      int edges, stalls, first_we;
      logic [7:0] tbl [N] = '{3, 71, 18, 115, 35, 31, 89, 31, 17, 5, 8, 14, 2, 5};
      for (int i = 0; i < N; i++) lut[i] = tbl[i];
      do_pass(1'b0, -1, edges, stalls, first_we);
      n_checks++;
      if (first_we != 2) begin
         n_fail++; $display("FAIL first_we_edge: got %0d required 2", first_we);
      end
      n_checks++;
      if (edges != 1 + 2 * N) begin
         n_fail++; $display("FAIL basic_done_edge: got %0d required %0d", edges, 1 + 2 * N);
      end
      n_checks++;
      if (qa_addr.size() != N) begin
         n_fail++; $display("FAIL basic_count: got %0d required %0d", qa_addr.size(), N);
      end
      for (int i = 0; i < N && i < qa_addr.size(); i++) begin
         n_checks++;
         if (qa_addr[i] !== 8'(i) || qa_data[i] !== lut[i]) begin
            n_fail++;
            $display("FAIL basic_write%0d: got addr %0d data %0d required addr %0d data %0d",
                     i, qa_addr[i], qa_data[i], i, lut[i]);
         end
      end
      n_checks++;
      if (checksum_a !== model_checksum() || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_checksum: got %0d busy %0b required %0d busy 0",
                  checksum_a, busy_a, model_checksum());
      end
   endtask

   task automatic test_backpressure();
      int edges = 1, stalled = 0;
      logic rdy;
      randomize_lut();
      clear_queues();
      step(1'b1, 1'b1);
      while (!done_a && edges < 500) begin
         rdy = !(mem_we_a && lut_idx_a == 6'd3 && stalled < 5);
         if (!rdy) begin
            stalled++;
            n_checks++;
            if (mem_we_a !== 1'b1 || mem_addr_a !== 8'd3 || mem_wdata_a !== lut[3]) begin
               n_fail++;
               $display("FAIL stall_frozen: got we %0b addr %0d data %0d required 1 3 %0d",
                        mem_we_a, mem_addr_a, mem_wdata_a, lut[3]);
            end
         end
         step(1'b0, rdy);
         edges++;
      end
      n_checks++;
      if (edges != 1 + 2 * N + 5) begin
         n_fail++; $display("FAIL stall_done_edge: got %0d required %0d", edges, 1 + 2 * N + 5);
      end
      n_checks++;
      if (qa_addr.size() != N) begin
         n_fail++; $display("FAIL stall_count: got %0d required %0d", qa_addr.size(), N);
      end
      for (int i = 0; i < N && i < qa_addr.size(); i++) begin
         n_checks++;
         if (qa_addr[i] !== 8'(i) || qa_data[i] !== lut[i]) begin
            n_fail++;
            $display("FAIL stall_write%0d: got %0d/%0d required %0d/%0d", i, qa_addr[i], qa_data[i], i, lut[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int edges, stalls, first_we;
      randomize_lut();
      do_pass(1'b1, 6, edges, stalls, first_we);
      n_checks++;
      if (edges != 1 + 2 * N + stalls) begin
         n_fail++; $display("FAIL busy_start_edge: got %0d required %0d", edges, 1 + 2 * N + stalls);
      end
      n_checks++;
      if (qa_addr.size() != N) begin
         n_fail++; $display("FAIL busy_start_count: got %0d required %0d", qa_addr.size(), N);
      end
      for (int i = 0; i < N && i < qa_addr.size(); i++) begin
         n_checks++;
         if (qa_addr[i] !== 8'(i) || qa_data[i] !== lut[i]) begin
            n_fail++;
            $display("FAIL busy_start_write%0d: got %0d/%0d required %0d/%0d", i, qa_addr[i], qa_data[i], i, lut[i]);
         end
      end
      n_checks++;
      if (checksum_a !== model_checksum()) begin
         n_fail++; $display("FAIL busy_start_checksum: got %0d required %0d", checksum_a, model_checksum());
      end
   endtask

   task automatic test_reset_mid_pass();
      int edges = 1, stalls, first_we;
      randomize_lut();
      clear_queues();
      step(1'b1, 1'b1);
      while (!(mem_we_a && lut_idx_a == 6'd9) && edges < 500) begin
         step(1'b0, 1'b1);
         edges++;
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({mem_we_a, busy_a, done_a, lut_idx_a, mem_addr_a, mem_wdata_a, checksum_a} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: outputs %h required 0",
                  {mem_we_a, busy_a, done_a, lut_idx_a, mem_addr_a, mem_wdata_a, checksum_a});
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) step(1'b0, 1'b1);
      n_checks++;
      if (qa_addr.size() != 9 || busy_a !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_write: got %0d writes busy %0b required 9 busy 0", qa_addr.size(), busy_a);
      end
      do_pass(1'b1, -1, edges, stalls, first_we);
      n_checks++;
      if (qa_addr.size() != N || edges != 1 + 2 * N + stalls) begin
         n_fail++;
         $display("FAIL reset_restart: got %0d writes edge %0d required %0d writes edge %0d",
                  qa_addr.size(), edges, N, 1 + 2 * N + stalls);
      end
      for (int i = 0; i < N && i < qa_addr.size(); i++) begin
         n_checks++;
         if (qa_addr[i] !== 8'(i) || qa_data[i] !== lut[i]) begin
            n_fail++;
            $display("FAIL restart_write%0d: got %0d/%0d required %0d/%0d", i, qa_addr[i], qa_data[i], i, lut[i]);
         end
      end
   endtask

   task automatic test_addr_wrap();
      int edges, stalls, first_we;
      logic [7:0] ea;
      randomize_lut();
      do_pass(1'b1, -1, edges, stalls, first_we);
      n_checks++;
      if (qb_addr.size() != N || done_b !== 1'b1) begin
         n_fail++; $display("FAIL wrap_count: got %0d done %0b required %0d done 1", qb_addr.size(), done_b, N);
      end
      for (int i = 0; i < N && i < qb_addr.size(); i++) begin
         ea = 8'((BASE_B + i) % 256);
         n_checks++;
         if (qb_addr[i] !== ea || qb_data[i] !== lut[i]) begin
            n_fail++;
            $display("FAIL wrap_write%0d: got %0d/%0d required %0d/%0d", i, qb_addr[i], qb_data[i], ea, lut[i]);
         end
      end
   endtask

   task automatic test_restart_in_done();
      int edges, stalls, first_we;
      logic [7:0] sa[$], sd[$];
      logic [7:0] ck1;
      randomize_lut();
      do_pass(1'b0, -1, edges, stalls, first_we);
      sa = qa_addr; sd = qa_data; ck1 = checksum_a;
      n_checks++;
      if (ck1 !== model_checksum()) begin
         n_fail++; $display("FAIL done_checksum: got %0d required %0d", ck1, model_checksum());
      end
      clear_queues();
      step(1'b1, 1'b1);
      edges = 1;
      n_checks++;
      if (done_a !== 1'b0 || checksum_a !== 8'd0 || busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_clear: got done %0b ck %0d busy %0b required 0 0 1", done_a, checksum_a, busy_a);
      end
      while (!done_a && edges < 500) begin
         step(1'b0, 1'b1);
         edges++;
      end
      n_checks++;
      if (edges != 1 + 2 * N || qa_addr.size() != sa.size() || checksum_a !== ck1) begin
         n_fail++;
         $display("FAIL second_pass: got edge %0d writes %0d ck %0d required %0d %0d %0d",
                  edges, qa_addr.size(), checksum_a, 1 + 2 * N, sa.size(), ck1);
      end
      for (int i = 0; i < sa.size() && i < qa_addr.size(); i++) begin
         n_checks++;
         if (qa_addr[i] !== sa[i] || qa_data[i] !== sd[i]) begin
            n_fail++;
            $display("FAIL second_write%0d: got %0d/%0d required %0d/%0d", i, qa_addr[i], qa_data[i], sa[i], sd[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_pass();
      test_addr_wrap();
      test_restart_in_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
